// File: rtl/muldiv_issue_if.sv
// Signal bundle between the RV32M issue stage, its requester, the mul/div unit and writeback.
// The issue stage uses the slave modport; the environment around it uses the master modport.
interface muldiv_issue_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_instr_i;
   logic [31:0] req_ra_i;
   logic [31:0] req_rb_i;
   logic        md_valid_o;
   logic [7:0]  md_op_o;
   logic [31:0] md_ra_o;
   logic [31:0] md_rb_o;
   logic        md_stall_i;
   logic        md_ready_i;
   logic [31:0] md_result_i;
   logic        wb_valid_o;
   logic        wb_ack_i;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        illegal_o;
   logic        timeout_o;

   modport slave (
      input  req_valid_i, req_instr_i, req_ra_i, req_rb_i,
      input  md_stall_i, md_ready_i, md_result_i, wb_ack_i,
      output req_ready_o, md_valid_o, md_op_o, md_ra_o, md_rb_o,
      output wb_valid_o, wb_rd_o, wb_data_o, illegal_o, timeout_o
   );

   modport master (
      output req_valid_i, req_instr_i, req_ra_i, req_rb_i,
      output md_stall_i, md_ready_i, md_result_i, wb_ack_i,
      input  req_ready_o, md_valid_o, md_op_o, md_ra_o, md_rb_o,
      input  wb_valid_o, wb_rd_o, wb_data_o, illegal_o, timeout_o
   );
endinterface

// File: rtl/muldiv_issue.sv
// Single-outstanding RV32M issue stage: decodes, issues to the mul/div unit, waits with a
// latency watchdog, and holds the result for writeback until acknowledged.
module muldiv_issue #(
   parameter int unsigned MAX_LAT = 40
) (
   input logic           clk_i,
   input logic           rst_ni,
   muldiv_issue_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_e;

   localparam logic [5:0] MaxLat = 6'(MAX_LAT);

   state_e      r_state;
   state_e      w_state_nxt;
   logic        r_live;
   logic [7:0]  r_op;
   logic [31:0] r_ra;
   logic [31:0] r_rb;
   logic [4:0]  r_rd;
   logic [31:0] r_data;
   logic [5:0]  r_cnt;
   logic        r_illegal;
   logic        r_timeout;

   logic        w_legal;
   logic        w_accept;
   logic        w_lat_hit;
   logic [7:0]  w_op_dec;
   logic        w_unused;

   assign w_legal  = (bus.req_instr_i[6:0] == 7'b0110011) &&
                     (bus.req_instr_i[31:25] == 7'b0000001);
   assign w_op_dec = 8'd1 << bus.req_instr_i[14:12];
   assign w_unused = ^bus.req_instr_i[24:15];

   // r_live keeps ready low after reset until an edge has seen the unit not stalled.
   assign bus.req_ready_o = r_live && (r_state == StIdle) && !bus.md_stall_i;
   assign w_accept        = bus.req_valid_i && bus.req_ready_o;
   assign w_lat_hit       = (r_cnt + 6'd1) == MaxLat;

   assign bus.md_valid_o = (r_state == StIssue) && !bus.md_stall_i;
   assign bus.md_op_o    = bus.md_valid_o ? r_op : 8'h00;
   assign bus.md_ra_o    = r_ra;
   assign bus.md_rb_o    = r_rb;
   assign bus.wb_valid_o = (r_state == StWb);
   assign bus.wb_rd_o    = r_rd;
   assign bus.wb_data_o  = r_data;
   assign bus.illegal_o  = r_illegal;
   assign bus.timeout_o  = r_timeout;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_accept && w_legal) w_state_nxt = StIssue;
         StIssue: if (!bus.md_stall_i) w_state_nxt = StWait;
         StWait: begin
            // A result arriving on the last allowed cycle beats the timeout.
            if (bus.md_ready_i)  w_state_nxt = (r_rd != 5'd0) ? StWb : StIdle;
            else if (w_lat_hit) w_state_nxt = StIdle;
         end
         StWb:    if (bus.wb_ack_i) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= StIdle;
         r_live    <= 1'b0;
         r_op      <= 8'h00;
         r_ra      <= 32'd0;
         r_rb      <= 32'd0;
         r_rd      <= 5'd0;
         r_data    <= 32'd0;
         r_cnt     <= 6'd0;
         r_illegal <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_live    <= r_live || !bus.md_stall_i;
         r_illegal <= w_accept && !w_legal;
         if (w_accept && w_legal) begin
            r_op <= w_op_dec;
            r_ra <= bus.req_ra_i;
            r_rb <= bus.req_rb_i;
            r_rd <= bus.req_instr_i[11:7];
         end
         r_cnt <= (r_state == StWait) ? r_cnt + 6'd1 : 6'd0;
         if (r_state == StWait) begin
            if (bus.md_ready_i)  r_data    <= bus.md_result_i;
            else if (w_lat_hit) r_timeout <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_issue.sv
// Directed bench for muldiv_issue: stimulus pushes expected unit issues, writebacks and
// illegal pulses into a scoreboard that a negedge monitor drains as the DUT produces them.
module tb_muldiv_issue;
   typedef enum logic [1:0] {EvMd, EvWb, EvIll} ev_e;
   typedef struct {
      ev_e         kind;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } ev_t;

   logic clk = 1'b0;
   logic rst_ni;
   int   n_checks = 0;
   int   n_errors = 0;
   ev_t  sb_q[$];

   muldiv_issue_if bus();

   muldiv_issue #(.MAX_LAT(4)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endfunction

   function automatic void push(input ev_e k, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c);
      ev_t e;
      e.kind = k;
      e.a = a;
      e.b = b;
      e.c = c;
      sb_q.push_back(e);
   endfunction

   function automatic void pop_chk(input ev_e k, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] c);
      ev_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL unexpected event: got kind %0d, expected none", k);
      end else begin
         e = sb_q.pop_front();
         chk("event kind", 32'(k), 32'(e.kind));
         chk("event field a", a, e.a);
         chk("event field b", b, e.b);
         chk("event field c", c, e.c);
      end
   endfunction

   always @(negedge clk) begin
      if (bus.md_valid_o) pop_chk(EvMd, 32'(bus.md_op_o), bus.md_ra_o, bus.md_rb_o);
      else chk("md_op zero when idle", 32'(bus.md_op_o), 32'h0);
      if (bus.illegal_o) pop_chk(EvIll, 32'h0, 32'h0, 32'h0);
      if (bus.wb_valid_o && bus.wb_ack_i) pop_chk(EvWb, 32'(bus.wb_rd_o), bus.wb_data_o, 32'h0);
   end

   function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
      return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      #2;
   endtask

   // Present one instruction, let it be taken at the next edge, and return just after it.
   task automatic offer(input logic [31:0] instr, input logic [31:0] ra, input logic [31:0] rb);
      bus.req_valid_i = 1'b1;
      bus.req_instr_i = instr;
      bus.req_ra_i    = ra;
      bus.req_rb_i    = rb;
      tick();
      bus.req_valid_i = 1'b0;
   endtask

   initial begin
      rst_ni          = 1'b0;
      bus.req_valid_i = 1'b0;
      bus.req_instr_i = 32'h0;
      bus.req_ra_i    = 32'h0;
      bus.req_rb_i    = 32'h0;
      bus.md_stall_i  = 1'b0;
      bus.md_ready_i  = 1'b0;
      bus.md_result_i = 32'h0;
      bus.wb_ack_i    = 1'b0;

      #3;
      chk("reset req_ready", 32'(bus.req_ready_o), 32'h0);
      chk("reset md_valid", 32'(bus.md_valid_o), 32'h0);
      chk("reset wb_valid", 32'(bus.wb_valid_o), 32'h0);
      chk("reset illegal", 32'(bus.illegal_o), 32'h0);
      chk("reset timeout", 32'(bus.timeout_o), 32'h0);
      chk("reset md_ra", bus.md_ra_o, 32'h0);
      #4 bus.md_stall_i = 1'b1;
      #5 rst_ni = 1'b1;
      tick();
      bus.md_stall_i = 1'b0;
      probe();
      chk("ready before unstalled edge", 32'(bus.req_ready_o), 32'h0);
      tick();
      probe();
      chk("ready after unstalled edge", 32'(bus.req_ready_o), 32'h1);

      // MUL x5 = 7 * 6
      push(EvMd, 32'h01, 32'd7, 32'd6);
      offer(32'h022082B3, 32'd7, 32'd6);
      probe();
      chk("mul req_ready busy", 32'(bus.req_ready_o), 32'h0);
      chk("mul md_valid T+1", 32'(bus.md_valid_o), 32'h1);
      chk("mul md_op", 32'(bus.md_op_o), 32'h01);
      tick();
      probe();
      chk("mul single pulse", 32'(bus.md_valid_o), 32'h0);
      bus.md_ready_i  = 1'b1;
      bus.md_result_i = 32'd42;
      push(EvWb, 32'd5, 32'd42, 32'h0);
      tick();
      bus.md_ready_i = 1'b0;
      bus.md_result_i = 32'h0;
      probe();
      chk("mul wb_valid R+1", 32'(bus.wb_valid_o), 32'h1);
      chk("mul wb_rd", 32'(bus.wb_rd_o), 32'd5);
      chk("mul wb_data", bus.wb_data_o, 32'd42);
      tick();
      probe();
      chk("mul wb_valid held", 32'(bus.wb_valid_o), 32'h1);
      chk("mul wb_data held", bus.wb_data_o, 32'd42);
      bus.wb_ack_i = 1'b1;
      tick();
      bus.wb_ack_i = 1'b0;
      probe();
      chk("mul wb_valid after ack", 32'(bus.wb_valid_o), 32'h0);
      chk("mul ready after ack", 32'(bus.req_ready_o), 32'h1);

      // ADD is not RV32M
      push(EvIll, 32'h0, 32'h0, 32'h0);
      offer(32'h002082B3, 32'd1, 32'd2);
      probe();
      chk("add illegal pulse", 32'(bus.illegal_o), 32'h1);
      chk("add ready stays", 32'(bus.req_ready_o), 32'h1);
      chk("add no issue", 32'(bus.md_valid_o), 32'h0);
      tick();
      probe();
      chk("add illegal one cycle", 32'(bus.illegal_o), 32'h0);
      chk("add still no issue", 32'(bus.md_valid_o), 32'h0);

      // DIV x7 under a 3-cycle stall; md_ready during ISSUE must be ignored
      push(EvMd, 32'h10, 32'd100, 32'd7);
      offer(mk(3'd4, 5'd7), 32'd100, 32'd7);
      bus.md_stall_i  = 1'b1;
      bus.md_ready_i  = 1'b1;
      bus.md_result_i = 32'hDEAD;
      probe();
      chk("div stalled 1", 32'(bus.md_valid_o), 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         probe();
         chk("div stalled", 32'(bus.md_valid_o), 32'h0);
      end
      tick();
      bus.md_stall_i = 1'b0;
      probe();
      chk("div issue on unstall", 32'(bus.md_valid_o), 32'h1);
      chk("div md_op", 32'(bus.md_op_o), 32'h10);
      tick();
      bus.md_ready_i = 1'b0;
      probe();
      chk("div issue-cycle ready ignored", 32'(bus.wb_valid_o), 32'h0);
      bus.md_ready_i  = 1'b1;
      bus.md_result_i = 32'd14;
      push(EvWb, 32'd7, 32'd14, 32'h0);
      tick();
      bus.md_ready_i = 1'b0;
      probe();
      chk("div wb_valid", 32'(bus.wb_valid_o), 32'h1);
      chk("div wb_data", bus.wb_data_o, 32'd14);
      bus.wb_ack_i = 1'b1;
      tick();
      bus.wb_ack_i = 1'b0;

      // REMU to x0: result discarded
      push(EvMd, 32'h80, 32'h55, 32'd3);
      offer(mk(3'd7, 5'd0), 32'h55, 32'd3);
      probe();
      chk("remu md_op", 32'(bus.md_op_o), 32'h80);
      tick();
      bus.md_ready_i  = 1'b1;
      bus.md_result_i = 32'h1234;
      tick();
      bus.md_ready_i = 1'b0;
      probe();
      chk("remu x0 no wb", 32'(bus.wb_valid_o), 32'h0);
      chk("remu idle next cycle", 32'(bus.req_ready_o), 32'h1);
      tick();
      probe();
      chk("remu x0 still no wb", 32'(bus.wb_valid_o), 32'h0);

      // MULHSU: result on the final allowed WAIT cycle wins over timeout
      push(EvMd, 32'h04, 32'd9, 32'd10);
      offer(mk(3'd2, 5'd4), 32'd9, 32'd10);
      for (int i = 0; i < 4; i++) tick();
      bus.md_ready_i  = 1'b1;
      bus.md_result_i = 32'hABCD;
      push(EvWb, 32'd4, 32'hABCD, 32'h0);
      tick();
      bus.md_ready_i = 1'b0;
      probe();
      chk("edge ready wins wb", 32'(bus.wb_valid_o), 32'h1);
      chk("edge ready no timeout", 32'(bus.timeout_o), 32'h0);
      bus.wb_ack_i = 1'b1;
      tick();
      bus.wb_ack_i = 1'b0;

      // MULHU: unit never answers
      push(EvMd, 32'h08, 32'd1, 32'd2);
      offer(mk(3'd3, 5'd9), 32'd1, 32'd2);
      for (int i = 0; i < 4; i++) tick();
      probe();
      chk("timeout not yet", 32'(bus.timeout_o), 32'h0);
      chk("busy during wait", 32'(bus.req_ready_o), 32'h0);
      tick();
      probe();
      chk("timeout set", 32'(bus.timeout_o), 32'h1);
      chk("timeout no wb", 32'(bus.wb_valid_o), 32'h0);
      chk("timeout back to idle", 32'(bus.req_ready_o), 32'h1);

      // MULH accepted after timeout; flag stays sticky
      push(EvMd, 32'h02, 32'hFFFF_FFFD, 32'd5);
      offer(mk(3'd1, 5'd3), 32'hFFFF_FFFD, 32'd5);
      probe();
      chk("mulh accepted", 32'(bus.md_valid_o), 32'h1);
      tick();
      bus.md_ready_i  = 1'b1;
      bus.md_result_i = 32'hFFFF_FFFF;
      push(EvWb, 32'd3, 32'hFFFF_FFFF, 32'h0);
      tick();
      bus.md_ready_i = 1'b0;
      probe();
      chk("mulh wb_valid", 32'(bus.wb_valid_o), 32'h1);
      chk("timeout sticky", 32'(bus.timeout_o), 32'h1);
      bus.wb_ack_i = 1'b1;
      tick();
      bus.wb_ack_i = 1'b0;

      // Reset asserted while waiting on the unit
      push(EvMd, 32'h01, 32'd2, 32'd3);
      offer(mk(3'd0, 5'd6), 32'd2, 32'd3);
      tick();
      rst_ni = 1'b0;
      probe();
      chk("rst req_ready", 32'(bus.req_ready_o), 32'h0);
      chk("rst md_valid", 32'(bus.md_valid_o), 32'h0);
      chk("rst md_op", 32'(bus.md_op_o), 32'h0);
      chk("rst md_ra", bus.md_ra_o, 32'h0);
      chk("rst md_rb", bus.md_rb_o, 32'h0);
      chk("rst wb_valid", 32'(bus.wb_valid_o), 32'h0);
      chk("rst wb_rd", 32'(bus.wb_rd_o), 32'h0);
      chk("rst wb_data", bus.wb_data_o, 32'h0);
      chk("rst illegal", 32'(bus.illegal_o), 32'h0);
      chk("rst timeout cleared", 32'(bus.timeout_o), 32'h0);
      tick();
      rst_ni          = 1'b1;
      bus.md_ready_i  = 1'b1;
      bus.md_result_i = 32'd99;
      for (int i = 0; i < 3; i++) begin
         tick();
         probe();
         chk("post-reset no wb", 32'(bus.wb_valid_o), 32'h0);
      end
      chk("post-reset ready", 32'(bus.req_ready_o), 32'h1);
      bus.md_ready_i = 1'b0;

      tick();
      chk("scoreboard drained", 32'(sb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/muldiv_issue.md
MULDIV_ISSUE -- requirements
Module: muldiv_issue

Interface
REQ-001 The module SHALL have parameter MAX_LAT, default 40: the maximum number of WAIT cycles allowed before timeout.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous and active-low.
REQ-004 req_valid_i  in  1  an instruction is offered.
REQ-005 req_ready_o  out  1  the block accepts the offered instruction.
REQ-006 req_instr_i  in  32  RV32 instruction word.
REQ-007 req_ra_i, req_rb_i  in  32 each  rs1 and rs2 operand values.
REQ-008 md_valid_o  out  1  issue pulse to the multiply/divide unit.
REQ-009 md_op_o  out  8  one-hot operation select: bit0 mul, bit1 mulh, bit2 mulhsu, bit3 mulhu, bit4 div, bit5 divu, bit6 rem, bit7 remu.
REQ-010 md_ra_o, md_rb_o  out  32 each  operands to the unit.
REQ-011 md_stall_i  in  1  the unit is busy.
REQ-012 md_ready_i  in  1  the unit's result is valid this cycle.
REQ-013 md_result_i  in  32  the unit's result.
REQ-014 wb_valid_o  out  1  a writeback is pending.
REQ-015 wb_ack_i  in  1  the writeback is consumed.
REQ-016 wb_rd_o  out  5  destination register.
REQ-017 wb_data_o  out  32  writeback data.
REQ-018 illegal_o  out  1  one-cycle pulse when a non-RV32M word is rejected.
REQ-019 timeout_o  out  1  sticky flag: the unit failed to respond.

Function
REQ-020 The FSM SHALL have four states: IDLE, ISSUE, WAIT, WB.
REQ-021 req_ready_o SHALL equal (state==IDLE) && !md_stall_i.
REQ-022 Accept SHALL occur when req_valid_i && req_ready_o.
  - Legal: opcode[6:0]==7'b0110011 and funct7==7'b0000001.
  - Op select: funct3 value k selects md_op_o bit k.
REQ-023 On an illegal accept, illegal_o SHALL be 1 for exactly the next cycle and the FSM SHALL stay in IDLE; nothing is issued.
REQ-024 On a legal accept, the block SHALL latch op, ra, rb and rd (instr[11:7]) and move to ISSUE.
REQ-025 In ISSUE:
  - md_valid_o SHALL be 1 for exactly one cycle, and only when md_stall_i==0.
  - If md_stall_i==1, the FSM SHALL hold in ISSUE with md_valid_o=0.
  - After the pulse, the FSM SHALL move to WAIT.
REQ-026 md_op_o SHALL be 8'h00 whenever md_valid_o==0, and one-hot whenever md_valid_o==1.
REQ-027 md_ra_o and md_rb_o SHALL hold the latched operands from accept until the next accept.
REQ-028 md_ready_i SHALL be ignored outside WAIT, including in the issue cycle itself.
REQ-029 In WAIT, the 6-bit latency counter SHALL start at 0 and increment each cycle.
  - On md_ready_i: capture md_result_i; go to WB if rd!=0, otherwise go to IDLE (x0 write discarded).
  - If the counter reaches MAX_LAT without md_ready_i: set timeout_o, go to IDLE, no writeback.
  - md_ready_i on the same cycle the counter reaches MAX_LAT SHALL win (result captured, no timeout).
REQ-030 In WB, wb_valid_o=1 and wb_rd_o/wb_data_o SHALL be held stable until wb_ack_i is sampled 1; the FSM SHALL then return to IDLE.
REQ-031 wb_valid_o SHALL be 0 in every state except WB.
REQ-032 Latency: accept at cycle T gives md_valid_o at T+1 if not stalled; md_ready_i at cycle R gives wb_valid_o at R+1.
REQ-033 At most one operation SHALL be in flight; req_ready_o SHALL be 0 from accept until return to IDLE.
REQ-034 timeout_o SHALL be cleared only by reset.

Reset
REQ-035 While rst_ni==0 (asynchronously):
  - state=IDLE; all outputs 0; latched registers 0; counter 0.
  - Reset asserted mid-operation SHALL abort it with no writeback and no md_valid_o.
REQ-036 After rst_ni deasserts, req_ready_o SHALL rise on the first clock edge where md_stall_i==0.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
  - MUL x5: instr 0x022082B3, ra=7, rb=6, unit returns 42 after 1 cycle -> one md_valid_o pulse with md_op_o=8'h01; wb_valid_o with rd=5, data=42 held until ack.
  - ADD: instr 0x002082B3 -> illegal_o pulses once; md_valid_o stays 0; req_ready_o stays 1.
  - md_stall_i=1 for 3 cycles after a DIV accept -> md_valid_o fires on the first cycle stall drops, with md_op_o=8'h10.
  - REMU with rd=0, result 0x1234 -> no wb_valid_o; FSM back in IDLE the cycle after md_ready_i.
  - MAX_LAT=4, unit never ready -> timeout_o=1 after 4 WAIT cycles; wb_valid_o stays 0; next instruction is accepted.
  - rst_ni pulsed low during WAIT, then unit asserts md_ready_i -> no writeback; all outputs 0.
